bin2bcd_seq: RTL and testbench
==============================

// Module: bin2bcd_seq
// PURPOSE
//   Sequential double-dabble binary-to-BCD converter built around the add-3 digit-correction step.
//   Accepts one unsigned binary word on a start pulse and performs one shift-and-correct iteration per clock.
//   Presents the packed BCD result with a one-cycle done strobe.
//   Sits between the binary datapath and the BCD/seven-segment display stage.
// PARAMETERS
//   WIDTH   8  bit width of the binary input
//   DIGITS  3  number of BCD digits produced; must satisfy 10**DIGITS > 2**WIDTH-1
// PORTS
//   clk      in   1           system clock, rising edge
//   rst_n    in   1           asynchronous reset, active low
//   start    in   1           request conversion; sampled only in IDLE
//   bin_in   in   WIDTH       unsigned binary operand; sampled on the accepting edge
//   busy     out  1           conversion in progress
//   done     out  1           one-cycle pulse; bcd_out valid and updated
//   bcd_out  out  4*DIGITS    packed BCD; digit i in bits [4i+3:4i]; digit 0 = units
// BEHAVIOUR
//   Clock and reset
//   - One clock; reset is asynchronous and active-low.
//   - rst_n=0 forces state=IDLE, busy=0, done=0, bcd_out=0, and clears the internal shift register and counter, immediately.
//   - A reset mid-conversion discards the operation and leaves no partial result on bcd_out.
//   FSM states: IDLE, SHIFT.
//   IDLE
//   - busy=0.
//   - start=1 at an edge loads {DIGITS*4 zeros, bin_in} into the scratch register and cnt=WIDTH, then moves to SHIFT.
//   SHIFT (busy=1) -- each edge performs one iteration:
//     a) Correct every 4-bit BCD digit with the add-3 table:
//        - 0..4 pass unchanged.
//        - 5..9 map to the value + 3.
//        - 10..15 map to 0; these values are unreachable when DIGITS is legal.
//     b) Shift the whole scratch register {bcd, bin} left by 1. The MSB of the binary part enters bit 0 of digit 0.
//     c) Decrement cnt.
//   - On the edge where cnt goes 1->0:
//     - The shifted BCD part is loaded into bcd_out.
//     - done=1 for exactly that following cycle.
//     - State returns to IDLE.
//   Latency and output holding
//   - Start is accepted at edge E0; done is high in the cycle after edge E0+WIDTH.
//   - busy is high in the WIDTH cycles after E0.
//   - done pulses for exactly one cycle, then returns to 0.
//   - bcd_out holds its value until the next completion. It does not change while busy.
//   Handshake rules
//   - start while busy=1 is ignored (no queueing); bin_in changes during SHIFT have no effect.
//   - start high in the done cycle (state IDLE) is accepted, so back-to-back conversions run every WIDTH+1 cycles.
//   - start held high continuously restarts a conversion on each return to IDLE.
//   Widths
//   - Scratch register is 4*DIGITS+WIDTH bits.
//   - cnt is $clog2(WIDTH+1) bits.
//   - Arithmetic is unsigned; no truncation occurs when the DIGITS constraint holds.
// TESTING
//   1. Reset, then bin_in=8'd0 with start -> done after 8 cycles, bcd_out=12'h000, busy high exactly 8 cycles.
//   2. bin_in=8'd255 -> bcd_out=12'h255; bin_in=8'd99 -> 12'h099; bin_in=8'd100 -> 12'h100.
//   3. Start 8'd37, then pulse start with 8'd200 at cycle 3 of busy -> result 12'h037, second request ignored.
//   4. Start asserted in the done cycle with 8'd128 -> next done 9 cycles after the previous one, bcd_out=12'h128.
//   5. Start 8'd255, assert rst_n=0 at cycle 4 -> busy=0, done=0, bcd_out=0 immediately; no done follows release.
//   6. WIDTH=12, DIGITS=4: exhaustive 0..4095 -> bcd_out equals the decimal digits of each input; done every 13 cycles.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
// Each clock in SHIFT does one add-3 correction followed by one left shift.
// A WIDTH-bit word needs WIDTH iterations to convert.
// Ports:
//   clk     - system clock, rising edge
//   rst_n   - asynchronous reset, active low
//   start   - conversion request; only sampled while idle
//   bin_in  - unsigned binary operand; captured on the accepting edge
//   busy    - high while a conversion is in progress
//   done    - one-cycle strobe; bcd_out has just been updated
//   bcd_out - packed BCD result; digit i sits in bits [4i+3:4i], digit 0 is units
module bin2bcd_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SCR_W = BCD_W + WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [SCR_W-1:0]   scr_q, scr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;

  logic [SCR_W-1:0]   corr;
  logic [SCR_W-1:0]   shifted;

  // Add-3 correction for one digit. Codes 10..15 cannot occur with legal DIGITS.
  function automatic logic [3:0] add3(input logic [3:0] d);
    logic [3:0] r;
    case (d)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4: r = d;
      4'd5, 4'd6, 4'd7, 4'd8, 4'd9: r = d + 4'd3;
      default:                      r = 4'd0;
    endcase
    return r;
  endfunction

  // Correct every BCD digit, then shift the whole scratch register left by one.
  always_comb begin
    corr = scr_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      corr[WIDTH + 4*i +: 4] = add3(scr_q[WIDTH + 4*i +: 4]);
    end
    shifted = corr << 1;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          scr_d   = {BCD_W'(0), bin_in};
          cnt_d   = CNT_W'(WIDTH);
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        scr_d = shifted;
        cnt_d = cnt_q - CNT_W'(1);
        // Final iteration: publish the BCD half of the shifted register.
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = shifted[SCR_W-1 -: BCD_W];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      scr_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: an 8-bit/3-digit instance for the
// vector table, random values and handshake corners, and a 12-bit/4-digit
// instance swept exhaustively.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start8;
  logic [7:0]  bin8;
  logic        busy8;
  logic        done8;
  logic [11:0] bcd8;
  logic        start12;
  logic [11:0] bin12;
  logic        busy12;
  logic        done12;
  logic [15:0] bcd12;

  int n_chk;
  int n_err;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .bin_in(bin8),
    .busy(busy8), .done(done8), .bcd_out(bcd8)
  );

  bin2bcd_seq #(.WIDTH(12), .DIGITS(4)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .start(start12), .bin_in(bin12),
    .busy(busy12), .done(done12), .bcd_out(bcd12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] exp;
  } vec_t;

  // Reference: decimal digits of v by plain division.
  function automatic logic [31:0] ref_bcd(input int unsigned v, input int unsigned digits);
    logic [31:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int unsigned i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One conversion on the 8-bit instance; checks latency, busy length, result and pulse width.
  task automatic run8(input logic [7:0] v, input logic [11:0] exp, input string name);
    int lat;
    int bcnt;
    @(negedge clk);
    start8 = 1'b1;
    bin8   = v;
    @(negedge clk);
    start8 = 1'b0;
    bin8   = 8'($urandom);
    lat  = 1;
    bcnt = 0;
    while (!done8 && lat < 40) begin
      if (busy8) bcnt++;
      check({name, "_hold"}, 32'(bcd8 !== exp || lat > 0), 32'd1);
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'd9);
    check({name, "_busy_cycles"}, 32'(bcnt), 32'd8);
    check({name, "_bcd"}, 32'(bcd8), 32'(exp));
    check({name, "_busy_at_done"}, 32'(busy8), 32'd0);
    @(negedge clk);
    check({name, "_done_pulse"}, 32'(done8), 32'd0);
  endtask

  initial begin
    vec_t vecs[8];
    int lat;
    logic [7:0] rv;
    logic [11:0] prev;
    n_chk   = 0;
    n_err   = 0;
    start8  = 1'b0;
    bin8    = '0;
    start12 = 1'b0;
    bin12   = '0;
    rst_n   = 1'b0;

    vecs[0] = '{8'd0,   12'h000};
    vecs[1] = '{8'd255, 12'h255};
    vecs[2] = '{8'd99,  12'h099};
    vecs[3] = '{8'd100, 12'h100};
    vecs[4] = '{8'd1,   12'h001};
    vecs[5] = '{8'd9,   12'h009};
    vecs[6] = '{8'd10,  12'h010};
    vecs[7] = '{8'd199, 12'h199};

    // Reset state
    #12;
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_bcd",  32'(bcd8),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      run8(vecs[i].bin, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Random values against the arithmetic reference
    for (int i = 0; i < 40; i++) begin
      rv = 8'($urandom);
      run8(rv, 12'(ref_bcd(32'(rv), 3)), $sformatf("rand%0d_%0d", i, rv));
    end

    // start during busy is ignored
    @(negedge clk);
    start8 = 1'b1;
    bin8   = 8'd37;
    @(negedge clk);
    start8 = 1'b0;
    lat    = 1;
    @(negedge clk);
    @(negedge clk);
    lat    = 3;
    start8 = 1'b1;
    bin8   = 8'd200;
    @(negedge clk);
    start8 = 1'b0;
    lat    = 4;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("ign_latency", 32'(lat), 32'd9);
    check("ign_bcd", 32'(bcd8), 32'h037);
    @(negedge clk);
    check("ign_no_queue_busy", 32'(busy8), 32'd0);
    @(negedge clk);
    check("ign_no_queue_busy2", 32'(busy8), 32'd0);

    // Start in the done cycle: next done 9 cycles later
    run8(8'd55, 12'h055, "pre_b2b");
    @(negedge clk);
    start8 = 1'b1;
    bin8   = 8'd64;
    @(negedge clk);
    start8 = 1'b0;
    lat    = 1;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_first_bcd", 32'(bcd8), 32'h064);
    start8 = 1'b1;
    bin8   = 8'd128;
    lat    = 0;
    @(negedge clk);
    start8 = 1'b0;
    lat    = 1;
    check("b2b_hold", 32'(bcd8), 32'h064);
    check("b2b_busy", 32'(busy8), 32'd1);
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_spacing", 32'(lat), 32'd9);
    check("b2b_bcd", 32'(bcd8), 32'h128);

    // Reset mid-conversion
    @(negedge clk);
    start8 = 1'b1;
    bin8   = 8'd255;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy8), 32'd0);
    check("midrst_done", 32'(done8), 32'd0);
    check("midrst_bcd",  32'(bcd8),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done8 || busy8) lat++;
    end
    check("midrst_no_done", 32'(lat), 32'd0);
    check("midrst_bcd_after", 32'(bcd8), 32'd0);

    // Exhaustive 12-bit sweep with start held high
    @(negedge clk);
    start12 = 1'b1;
    bin12   = 12'd0;
    prev    = '0;
    for (int v = 0; v < 4096; v++) begin
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!done12 && lat < 30);
      if (!done12) begin
        check($sformatf("w12_timeout_%0d", v), 32'(done12), 32'd1);
        break;
      end
      check($sformatf("w12_bcd_%0d", v), 32'(bcd12), ref_bcd(32'(v), 4));
      check($sformatf("w12_spacing_%0d", v), 32'(lat), 32'd13);
      if (v == 4095) start12 = 1'b0;
      else bin12 = 12'(v + 1);
      prev = 12'(v);
    end
    @(negedge clk);
    check("w12_last_idle", 32'(busy12), 32'd0);
    check("w12_last_id", 32'(prev), 32'd4095);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
